// File: rtl/move_queue_dispatcher.sv
// rtl/move_queue_dispatcher.sv - move loader, move FIFO and stepper dispatch FSM
// Optional MOVE_CANCEL_EN: adjacent inverse moves (e.g. R, Ri) are popped together and never issued.
module move_queue_dispatcher #(
  parameter int MOVES_PER_LOAD = 50,
  parameter int DEPTH          = 64,
  parameter int SETTLE_CYCLES  = 25000
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          load,
  input  logic [4*MOVES_PER_LOAD-1:0]   seq,
  input  logic                          go,
  input  logic                          move_done,
  output logic [3:0]                    next_move,
  output logic                          start_move,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          seq_done
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SCW = (MOVES_PER_LOAD > 1) ? $clog2(MOVES_PER_LOAD) : 1;
  localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, SETTLE, FINISH} state_t;
  state_t state, state_nx;

  logic                        scanning;
  logic [4*MOVES_PER_LOAD-1:0] scan_word;
  logic [SCW-1:0]              scan_idx;
  logic [3:0]                  scan_nib;
  logic                        nib_valid, full, push, issue, cancel;
  logic [1:0]                  pop_n;
  logic [3:0]                  mem [DEPTH];
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [3:0]                  head;
  logic [SW-1:0]               settle_cnt;

  // The loader shifts the latched word left, so the top nibble is always the one being scanned.
  assign scan_nib  = scan_word[4*MOVES_PER_LOAD-1 -: 4];
  assign nib_valid = scanning && (scan_nib >= 4'd2) && (scan_nib <= 4'd13);
  assign full      = (count == CW'(DEPTH));
  assign push      = nib_valid && (!full || (pop_n != 2'd0));
  assign head      = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scanning  <= 1'b0;
      scan_word <= '0;
      scan_idx  <= '0;
    end else if (scanning) begin
      scan_word <= scan_word << 4;
      scan_idx  <= scan_idx + SCW'(1);
      if (scan_idx == SCW'(MOVES_PER_LOAD - 1))
        scanning <= 1'b0;
    end else if (load) begin
      scanning  <= 1'b1;
      scan_word <= seq;
      scan_idx  <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= scan_nib;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(push) - CW'(pop_n);
      if (nib_valid && !push)
        overflow <= 1'b1;
    end
  end

`ifdef MOVE_CANCEL_EN
  logic [3:0] head_next;
  assign head_next = mem[rd_ptr + PW'(1)];
  assign cancel = (count >= CW'(2)) && (head[3:1] == head_next[3:1]) && (head[0] != head_next[0]);
`else
  assign cancel = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    pop_n    = 2'd0;
    issue    = 1'b0;
    case (state)
      IDLE:      if (go) state_nx = ISSUE;
      ISSUE: begin
        if (cancel) begin
          pop_n = 2'd2;
        end else if (count != '0) begin
          pop_n    = 2'd1;
          issue    = 1'b1;
          state_nx = WAIT_DONE;
        end else if (!scanning) begin
          state_nx = FINISH;
        end
      end
      WAIT_DONE: if (move_done) state_nx = (SETTLE_CYCLES == 0) ? ISSUE : SETTLE;
      SETTLE:    if (settle_cnt == '0) state_nx = ISSUE;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      start_move <= 1'b0;
      next_move  <= 4'd0;
    end else begin
      state      <= state_nx;
      start_move <= issue;
      if (issue)
        next_move <= head;
      // Preloaded while waiting so SETTLE lasts exactly SETTLE_CYCLES clocks.
      if (state == WAIT_DONE)
        settle_cnt <= SETTLE_LOAD;
      else if (state == SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - SW'(1);
    end
  end

  assign busy     = scanning || (state != IDLE);
  assign seq_done = (state == FINISH);
endmodule

// File: tb/tb_move_queue_dispatcher.sv
// tb/tb_move_queue_dispatcher.sv - directed-vector bench for move_queue_dispatcher
// Small configuration: 8 moves per load, 4-entry FIFO, 4-cycle settle.
module tb_move_queue_dispatcher;
  localparam int M = 8;
  localparam int D = 4;
  localparam int S = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           load = 1'b0;
  logic           go = 1'b0;
  logic           move_done = 1'b0;
  logic [4*M-1:0] seq = '0;
  logic [3:0]     next_move;
  logic           start_move, busy, overflow, seq_done;
  logic [2:0]     count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int go_cyc = 0;
  int done_cyc = 0;
  int done_pulses = 0;
  int done_timer = 0;
  bit auto_done = 1'b0;
  bit manual_done = 1'b0;
  logic [3:0] starts[$];
  int start_cyc[$];

  move_queue_dispatcher #(.MOVES_PER_LOAD(M), .DEPTH(D), .SETTLE_CYCLES(S)) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .seq(seq), .go(go),
    .move_done(move_done), .next_move(next_move), .start_move(start_move),
    .busy(busy), .overflow(overflow), .count(count), .seq_done(seq_done)
  );

  always #20 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Stepper model: answers each start_move with move_done ten cycles later.
  always @(negedge clock) begin
    move_done = 1'b0;
    if (auto_done && done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) move_done = 1'b1;
    end
    if (manual_done) begin
      move_done = 1'b1;
      manual_done = 1'b0;
    end
    if (start_move) begin
      starts.push_back(next_move);
      start_cyc.push_back(cyc);
      done_timer = 10;
    end
    if (seq_done) begin
      done_pulses++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input int i);
    return (starts.size() > i) ? 32'(starts[i]) : 32'hFFFF;
  endfunction

  function automatic logic [31:0] pick_cyc(input int i);
    return (start_cyc.size() > i) ? 32'(start_cyc[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    auto_done = 1'b0;
    tick(2);
    check("reset_outs", {start_move, seq_done, overflow, busy, count, next_move}, 32'h0);
    reset_n = 1'b1;
    tick(1);
    starts.delete();
    start_cyc.delete();
    done_pulses = 0;
    done_timer = 0;
  endtask

  task automatic load_word(input logic [4*M-1:0] w);
    @(negedge clock);
    seq = w;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clock);
    go_cyc = cyc;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    tick(1);
    check(tag, busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {R, U, Ri} with settle and 10-cycle move_done
    do_reset();
    auto_done = 1'b1;
    load_word(32'h2430_0000);
    wait_idle("t1_scan_idle", 50);
    check("t1_count_loaded", count, 3);
    pulse_go();
    wait_idle("t1_run_idle", 300);
    check("t1_nstarts", starts.size(), 3);
    check("t1_move0", pick(0), 2);
    check("t1_move1", pick(1), 4);
    check("t1_move2", pick(2), 3);
    check("t1_go_latency", pick_cyc(0) - go_cyc, 2);
    check("t1_move_spacing", pick_cyc(1) - pick_cyc(0), 16);
    check("t1_seq_done", done_pulses, 1);
    check("t1_count_end", count, 0);
    check("t1_next_move_hold", next_move, 3);

    // all-invalid word: nothing queued, immediate finish
    do_reset();
    load_word(32'hF10E_00F1);
    wait_idle("t2_scan_idle", 50);
    check("t2_count", count, 0);
    pulse_go();
    wait_idle("t2_run_idle", 50);
    check("t2_nstarts", starts.size(), 0);
    check("t2_seq_done", done_pulses, 1);
    check("t2_done_latency", done_cyc - go_cyc, 2);

    // second load during a scan is ignored
    do_reset();
    auto_done = 1'b1;
    load_word(32'h2000_0000);
    load_word(32'h4500_0000);
    wait_idle("t3_scan_idle", 50);
    check("t3_count", count, 1);
    pulse_go();
    wait_idle("t3_run_idle", 100);
    check("t3_nstarts", starts.size(), 1);
    check("t3_move0", pick(0), 2);

    // overflow: six valid moves into a four-entry FIFO
    do_reset();
    auto_done = 1'b1;
    load_word(32'h2468_AC00);
    wait_idle("t4_scan_idle", 50);
    check("t4_count_full", count, 4);
    check("t4_overflow", overflow, 1);
    pulse_go();
    wait_idle("t4_run_idle", 400);
    check("t4_nstarts", starts.size(), 4);
    check("t4_move0", pick(0), 2);
    check("t4_move1", pick(1), 4);
    check("t4_move2", pick(2), 6);
    check("t4_move3", pick(3), 8);
    check("t4_overflow_sticky", overflow, 1);

    // reset while a move is being issued
    do_reset();
    load_word(32'h2460_0000);
    wait_idle("t5_scan_idle", 50);
    pulse_go();
    begin
      int n = 0;
      while (!start_move && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    check("t5_start_seen", start_move, 1);
    reset_n = 1'b0;
    #1;
    check("t5_start_cleared", start_move, 0);
    check("t5_count_cleared", count, 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    starts.delete();
    done_pulses = 0;
    manual_done = 1'b1;
    tick(20);
    check("t5_no_starts", starts.size(), 0);
    check("t5_no_done", done_pulses, 0);
    check("t5_idle", busy, 0);

    // go while loader is mid-scan of {F, B}
    do_reset();
    auto_done = 1'b1;
    load_word(32'h0000_6A00);
    pulse_go();
    wait_idle("t6_run_idle", 300);
    check("t6_nstarts", starts.size(), 2);
    check("t6_move0", pick(0), 6);
    check("t6_move1", pick(1), 10);
    check("t6_seq_done", done_pulses, 1);

    // {R, Ri, U}: cancelled pair or full dispatch depending on the build
    do_reset();
    auto_done = 1'b1;
    load_word(32'h2340_0000);
    wait_idle("t7_scan_idle", 50);
    pulse_go();
    wait_idle("t7_run_idle", 300);
`ifdef MOVE_CANCEL_EN
    check("t7_nstarts", starts.size(), 1);
    check("t7_move0", pick(0), 4);
`else
    check("t7_nstarts", starts.size(), 3);
    check("t7_move0", pick(0), 2);
    check("t7_move1", pick(1), 3);
    check("t7_move2", pick(2), 4);
`endif
    check("t7_seq_done", done_pulses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/move_queue_dispatcher.md
MOVE_QUEUE_DISPATCHER -- requirements
Module: move_queue_dispatcher

Interface
REQ-001 SHALL have parameter MOVES_PER_LOAD, default 50: number of 4-bit move slots per load word.
REQ-002 SHALL have parameter DEPTH, default 64: FIFO entries; power of two, at least 4.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 25000: idle clocks after each move_done (1 ms at 25 MHz); 0 means no settle.
REQ-004 SHALL have port clock  input  1  25 MHz system clock; all logic on posedge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load  input  1  one-cycle pulse; capture seq.
REQ-007 SHALL have port seq  input  4*MOVES_PER_LOAD  packed moves; nibble MOVES_PER_LOAD-1 is issued first.
REQ-008 SHALL have port go  input  1  one-cycle pulse; arm dispatch.
REQ-009 SHALL have port move_done  input  1  stepper driver finished current move.
REQ-010 SHALL have port next_move  output  4  move code to the stepper driver.
REQ-011 SHALL have port start_move  output  1  one-cycle pulse; next_move is valid.
REQ-012 SHALL have port busy  output  1  loader active or dispatcher not IDLE.
REQ-013 SHALL have port overflow  output  1  sticky; a valid move was dropped because the FIFO was full.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-015 SHALL have port seq_done  output  1  one-cycle pulse; armed run completed.

Function
REQ-016 Valid moves SHALL be codes 2..13 (R, Ri, U, Ui, F, Fi, L, Li, B, Bi, D, Di); the loader skips codes 0, 1, 14 and 15 without writing them.
REQ-017 On load with the loader idle, the loader SHALL latch seq and scan one nibble per cycle, highest nibble first, for MOVES_PER_LOAD cycles.
REQ-018 A load pulse while the loader is scanning SHALL be ignored.
REQ-019 When the FIFO is full, a valid nibble SHALL be dropped and overflow set; scanning continues.
REQ-020 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full, and count SHALL remain unchanged.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 Dispatcher states SHALL be IDLE, ISSUE, WAIT_DONE, SETTLE and FINISH.
REQ-023 IDLE -> ISSUE SHALL occur on a go pulse; a go pulse in any other state SHALL be ignored.
REQ-024 In ISSUE with count > 0, the dispatcher SHALL pop the head, drive it on next_move, pulse start_move for one cycle, and go to WAIT_DONE.
REQ-025 In ISSUE with count = 0 and the loader idle, the dispatcher SHALL go to FINISH.
REQ-026 In ISSUE with count = 0 and the loader scanning, the dispatcher SHALL stay in ISSUE.
REQ-027 next_move SHALL hold its value from the start_move cycle until the next start_move.
REQ-028 move_done SHALL be sampled only in WAIT_DONE.
REQ-029 On move_done in WAIT_DONE, the dispatcher SHALL go to SETTLE, or directly to ISSUE if SETTLE_CYCLES = 0.
REQ-030 SETTLE SHALL last exactly SETTLE_CYCLES clocks and then go to ISSUE.
REQ-031 FINISH SHALL pulse seq_done for one cycle and then go to IDLE.
REQ-032 Latency from go to start_move, with a non-empty FIFO, SHALL be 2 clocks.

Reset
REQ-033 While reset_n is low, start_move, seq_done, overflow, count, busy and next_move SHALL be 0.
REQ-034 While reset_n is low, the FIFO pointers SHALL be cleared and the dispatcher held in IDLE.
REQ-035 Reset asserted mid-move SHALL deassert start_move immediately and discard the queue; move_done arriving after reset SHALL be ignored.

Configuration
REQ-036 With MOVE_CANCEL_EN defined: in ISSUE, when count >= 2 and the head and head+1 entries share bits [3:1] but differ in bit 0 (e.g. R then Ri), both SHALL be popped in one cycle without start_move, and the dispatcher stays in ISSUE.
REQ-037 With MOVE_CANCEL_EN undefined, every queued move SHALL be dispatched.

Verification
REQ-038 Load {R,U,Ri}, with SETTLE_CYCLES=4, then go; return move_done 10 cycles after each start -> next_move sequence 2, 4, 3, then seq_done pulses, count=0.
REQ-039 Load a word of all zeros -> count stays 0; go -> seq_done 2-3 cycles later with no start_move.
REQ-040 With DEPTH=4, load 6 valid moves -> count=4, overflow=1, and the first 4 moves are dispatched in order.
REQ-041 Pull reset_n low during WAIT_DONE -> start_move=0 and count=0 immediately; a later move_done produces no activity.
REQ-042 With MOVE_CANCEL_EN, load {R,Ri,U}, then go -> exactly one start_move, with next_move=4.
REQ-043 Pulse go while the loader is mid-scan of {F,B} -> both moves are dispatched (6, then 10) before seq_done.
